// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings, FSM states and address constants for pipe_ctrl
// Stall bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
package pipe_ctrl_pkg;

  localparam int          INST_ADDR_W = 32;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  localparam logic [5:0] STALL_NONE   = 6'b000000;
  localparam logic [5:0] STALL_ID     = 6'b000111;
  localparam logic [5:0] STALL_EX     = 6'b001111;
  localparam logic [5:0] STALL_MEM    = 6'b011111;
  localparam logic [5:0] STALL_REFILL = 6'b000011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  // The deepest requester freezes everything upstream of it, so it wins.
  function automatic logic [5:0] stall_prio(input logic id, input logic ex, input logic mem);
    logic [5:0] s;
    s = STALL_NONE;
    if (mem)     s = STALL_MEM;
    else if (ex) s = STALL_EX;
    else if (id) s = STALL_ID;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, exception flush/redirect/refill sequencer, stall watchdog
// Exception to RUN takes 2 + REFILL_CYCLES cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          REFILL_CYCLES = 2,
  parameter int          STALL_TIMEOUT = 1023,
  parameter int          CNT_W         = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic                   excp_valid,
  input  logic                   excp_eret,
  input  logic [INST_ADDR_W-1:0] epc_i,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [INST_ADDR_W-1:0] new_pc,
  output logic                   busy,
  output logic                   stall_timeout
);

  localparam logic [CNT_W-1:0] REFILL_LAST = CNT_W'(REFILL_CYCLES);
  localparam logic [CNT_W-1:0] WD_MAX      = CNT_W'(STALL_TIMEOUT);

  state_e                 state_q, state_d;
  logic                   flush_q, flush_d;
  logic [INST_ADDR_W-1:0] new_pc_q, new_pc_d;
  logic [CNT_W-1:0]       refill_cnt_q, refill_cnt_d;
  logic [CNT_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                   timeout_q, timeout_d;

  always_comb begin
    state_d      = state_q;
    flush_d      = 1'b0;
    new_pc_d     = new_pc_q;
    refill_cnt_d = refill_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    timeout_d    = timeout_q;
    stall        = STALL_NONE;

    case (state_q)
      ST_RUN: begin
        stall = stall_prio(stallreq_id, stallreq_ex, stallreq_mem);
        if (stall != STALL_NONE) begin
          if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
        end else begin
          wd_cnt_d = '0;
        end
        if (wd_cnt_d == WD_MAX) timeout_d = 1'b1;
        // The redirect also restarts the watchdog flag for the new instruction stream.
        if (excp_valid) begin
          state_d   = ST_FLUSH;
          flush_d   = 1'b1;
          new_pc_d  = excp_eret ? epc_i : EXC_VECTOR;
          timeout_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        refill_cnt_d = '0;
        state_d      = (REFILL_CYCLES > 0) ? ST_REFILL : ST_RUN;
      end
      ST_REFILL: begin
        stall        = STALL_REFILL;
        refill_cnt_d = refill_cnt_q + 1'b1;
        if (refill_cnt_d == REFILL_LAST) begin
          state_d      = ST_RUN;
          refill_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      flush_q      <= 1'b0;
      new_pc_q     <= ZERO_WORD;
      refill_cnt_q <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      new_pc_q     <= new_pc_d;
      refill_cnt_q <= refill_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign busy          = (state_q != ST_RUN);
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a cycle model and directed literals
// Instance 0 uses REFILL_CYCLES=2, instance 1 uses REFILL_CYCLES=0; both use STALL_TIMEOUT=8.
module tb_pipe_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id = 1'b0, ex = 1'b0, mem = 1'b0;
  logic        excp = 1'b0, eret = 1'b0;
  logic [31:0] epc = 32'h0;

  logic [5:0]  stall_o [2];
  logic        flush_o [2];
  logic [31:0] npc_o   [2];
  logic        busy_o  [2];
  logic        to_o    [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h20), .REFILL_CYCLES(2), .STALL_TIMEOUT(T), .CNT_W(10)) dut_a (
    .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex), .stallreq_mem(mem),
    .excp_valid(excp), .excp_eret(eret), .epc_i(epc),
    .stall(stall_o[0]), .flush(flush_o[0]), .new_pc(npc_o[0]), .busy(busy_o[0]),
    .stall_timeout(to_o[0]));

  pipe_ctrl #(.EXC_VECTOR(32'h20), .REFILL_CYCLES(0), .STALL_TIMEOUT(T), .CNT_W(10)) dut_b (
    .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex), .stallreq_mem(mem),
    .excp_valid(excp), .excp_eret(eret), .epc_i(epc),
    .stall(stall_o[1]), .flush(flush_o[1]), .new_pc(npc_o[1]), .busy(busy_o[1]),
    .stall_timeout(to_o[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: age counts cycles since an accepted exception (0 = running normally).
  int          age  [2];
  int          wd   [2];
  bit          flag [2];
  logic [31:0] mpc  [2];
  int          rc   [2] = '{2, 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        age[i] = 0; wd[i] = 0; flag[i] = 0; mpc[i] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (age[i] == 0) begin
          if (id || ex || mem) wd[i] = (wd[i] < T) ? wd[i] + 1 : T;
          else                 wd[i] = 0;
          if (wd[i] >= T) flag[i] = 1;
          if (excp) begin
            age[i]  = 1;
            mpc[i]  = eret ? epc : 32'h20;
            flag[i] = 0;
          end
        end else begin
          age[i] = age[i] + 1;
          if (age[i] > 1 + rc[i]) age[i] = 0;
        end
      end
    end
  end

  function automatic logic [5:0] exp_stall(input int a);
    if (a == 1) return 6'b000000;
    if (a > 1)  return 6'b000011;
    if (mem)    return 6'b011111;
    if (ex)     return 6'b001111;
    if (id)     return 6'b000111;
    return 6'b000000;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_stall", i), 32'(stall_o[i]), 32'(exp_stall(age[i])));
        chk($sformatf("m%0d_flush", i), 32'(flush_o[i]), 32'(age[i] == 1));
        chk($sformatf("m%0d_busy", i),  32'(busy_o[i]),  32'(age[i] != 0));
        chk($sformatf("m%0d_newpc", i), npc_o[i], mpc[i]);
        chk($sformatf("m%0d_tmo", i),   32'(to_o[i]),    32'(flag[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall_o[0]), 32'h0);
    chk("rst_flush", 32'(flush_o[0]), 32'h0);
    chk("rst_busy",  32'(busy_o[0]),  32'h0);
    chk("rst_newpc", npc_o[0], 32'h0);
    chk("rst_tmo",   32'(to_o[0]), 32'h0);
    rst = 1'b1;

    // priority
    id = 1; ex = 1; #1 chk("prio_id_ex", 32'(stall_o[0]), 32'h0f);
    tick(); mem = 1; #1 chk("prio_all", 32'(stall_o[0]), 32'h1f);
    tick(); id = 0; ex = 0; mem = 0; #1 chk("prio_none", 32'(stall_o[0]), 32'h00);
    tick();

    // exception, plus excp_valid held into FLUSH must be ignored
    excp = 1; eret = 0; #1 chk("exc_n_busy", 32'(busy_o[0]), 32'h0);
    tick(); #1;
    chk("exc_n1_flush", 32'(flush_o[0]), 32'h1);
    chk("exc_n1_pc",    npc_o[0], 32'h20);
    chk("exc_n1_stall", 32'(stall_o[0]), 32'h0);
    chk("exc_n1_busy",  32'(busy_o[0]), 32'h1);
    chk("b_n1_flush",   32'(flush_o[1]), 32'h1);
    tick(); excp = 0; #1;
    chk("exc_n2_stall", 32'(stall_o[0]), 32'h03);
    chk("exc_n2_busy",  32'(busy_o[0]), 32'h1);
    chk("exc_n2_flush", 32'(flush_o[0]), 32'h0);
    chk("b_n2_busy",    32'(busy_o[1]), 32'h0);
    chk("b_n2_flush",   32'(flush_o[1]), 32'h0);
    tick(); #1 chk("exc_n3_stall", 32'(stall_o[0]), 32'h03);
    tick(); #1;
    chk("exc_n4_busy",  32'(busy_o[0]), 32'h0);
    chk("exc_n4_stall", 32'(stall_o[0]), 32'h0);

    // ERET with a concurrent EX stall
    epc = 32'h0000_1234; eret = 1; excp = 1; ex = 1;
    #1 chk("eret_stall", 32'(stall_o[0]), 32'h0f);
    tick(); excp = 0; eret = 0; ex = 0; #1;
    chk("eret_flush", 32'(flush_o[0]), 32'h1);
    chk("eret_pc",    npc_o[0], 32'h1234);
    repeat (4) tick();
    #1 chk("eret_pc_hold", npc_o[0], 32'h1234);

    // watchdog: 7 stalled + idle stays clear, 8 stalled sets it
    mem = 1; repeat (7) tick();
    mem = 0; #1 chk("wd7_a", 32'(to_o[0]), 32'h0);
    tick(); #1 chk("wd7_b", 32'(to_o[0]), 32'h0);
    mem = 1; repeat (8) tick();
    #1 chk("wd8_set", 32'(to_o[0]), 32'h1);
    mem = 0; tick(); #1 chk("wd8_sticky", 32'(to_o[0]), 32'h1);
    excp = 1; tick(); excp = 0; #1;
    chk("wd_flush_clr", 32'(to_o[0]), 32'h0);
    chk("wd_flush",     32'(flush_o[0]), 32'h1);

    // asynchronous reset in the middle of REFILL
    tick(); #1 chk("pre_rst_busy", 32'(busy_o[0]), 32'h1);
    rst = 0; #1;
    chk("arst_stall", 32'(stall_o[0]), 32'h0);
    chk("arst_busy",  32'(busy_o[0]), 32'h0);
    chk("arst_flush", 32'(flush_o[0]), 32'h0);
    chk("arst_newpc", npc_o[0], 32'h0);
    chk("arst_tmo",   32'(to_o[0]), 32'h0);
    tick(); rst = 1;
    tick(); #1;
    chk("post_rst_busy",  32'(busy_o[0]), 32'h0);
    chk("post_rst_stall", 32'(stall_o[0]), 32'h0);
    chk("post_rst_newpc", npc_o[0], 32'h0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
